// File: rtl/mem_burst_master.sv
// Burst initiator for the main-memory port: checks a client request against the
// memory window, then sequences 1/4/8/16-word read or write bursts with a stall timeout.
module mem_burst_master #(
    parameter int unsigned              ADDRESS_SIZE  = 32,
    parameter int unsigned              DATA_SIZE     = 32,
    parameter logic [ADDRESS_SIZE-1:0]  START_ADDRESS = 'h8002_0000,
    parameter int unsigned              MEM_SIZE      = 1048576,
    parameter int unsigned              TIMEOUT       = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic                    req_wr,
    input  logic [1:0]              req_size,
    input  logic [DATA_SIZE-1:0]    wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    output logic [DATA_SIZE-1:0]    rd_data,
    output logic                    rd_valid,
    output logic                    done,
    output logic                    err,
    output logic                    mem_en,
    output logic                    mem_wren,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [1:0]              mem_acc_size,
    output logic [DATA_SIZE-1:0]    mem_d_in,
    input  logic [DATA_SIZE-1:0]    mem_d_out,
    input  logic                    mem_busy
);

    localparam int unsigned EW = ADDRESS_SIZE + 2;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [EW-1:0] WIN_END = EW'(MEM_SIZE);
    localparam logic [ADDRESS_SIZE-1:0] BEAT_BYTES = ADDRESS_SIZE'(4);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WRITE,
        ST_READ,
        ST_FINISH
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [1:0]              size_q, size_d;
    logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]              acc_size_q, acc_size_d;
    logic [4:0]              left_q, left_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic [DATA_SIZE-1:0]    rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [4:0]              beats_c;
    logic [EW-1:0]           offset_c;
    logic [EW-1:0]           span_c;
    logic                    reject_c;
    logic                    mem_en_c;
    logic                    beat_c;
    logic                    stall_c;

    // Beat count for the latched size code
    always_comb begin
        beats_c = 5'd1;
        unique case (size_q)
            2'b00:   beats_c = 5'd1;
            2'b01:   beats_c = 5'd4;
            2'b10:   beats_c = 5'd8;
            default: beats_c = 5'd16;
        endcase
    end

    // Window check done with two spare bits so the end-of-burst sum cannot wrap
    assign offset_c = {2'b00, addr_q} - {2'b00, START_ADDRESS};
    assign span_c   = offset_c + EW'({beats_c, 2'b00});
    assign reject_c = (addr_q[1:0] != 2'b00) || (addr_q < START_ADDRESS) || (span_c > WIN_END);

    assign mem_en_c = (state_q == ST_READ) || ((state_q == ST_WRITE) && wr_valid);
    assign beat_c   = mem_en_c && mem_busy;
    assign stall_c  = mem_en_c && !mem_busy;

    assign req_ready    = (state_q == ST_IDLE);
    assign mem_en       = mem_en_c;
    assign mem_wren     = mem_en_c && (state_q == ST_WRITE);
    assign mem_d_in     = (state_q == ST_WRITE) ? wr_data : '0;
    assign wr_ready     = beat_c && (state_q == ST_WRITE);
    assign mem_addr     = mem_addr_q;
    assign mem_acc_size = acc_size_q;
    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign done         = done_q;
    assign err          = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            mem_addr_q <= '0;
            acc_size_q <= 2'b00;
            left_q     <= 5'd0;
            tmo_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            mem_addr_q <= mem_addr_d;
            acc_size_q <= acc_size_d;
            left_q     <= left_d;
            tmo_q      <= tmo_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // done/err are registered so they appear during the single FINISH cycle
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        size_d     = size_q;
        mem_addr_d = mem_addr_q;
        acc_size_d = acc_size_q;
        left_d     = left_q;
        tmo_d      = tmo_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wr_d    = req_wr;
                    size_d  = req_size;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                tmo_d = '0;
                if (reject_c) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d    = wr_q ? ST_WRITE : ST_READ;
                    mem_addr_d = addr_q;
                    acc_size_d = size_q;
                    left_d     = beats_c;
                end
            end
            ST_WRITE, ST_READ: begin
                if (beat_c) begin
                    mem_addr_d = mem_addr_q + BEAT_BYTES;
                    left_d     = left_q - 5'd1;
                    tmo_d      = '0;
                    if (state_q == ST_READ) begin
                        rd_data_d  = mem_d_out;
                        rd_valid_d = 1'b1;
                    end
                    if (left_q == 5'd1) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                    end
                end else if (stall_c) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: a per-burst cycle model predicts every
// output from the request, the memory busy pattern and the client wr_valid pattern.
module tb_mem_burst_master;

    localparam int unsigned MEMSZ = 1048576;
    localparam int unsigned TMO   = 8;
    localparam int unsigned MAXC  = 512;
    localparam int unsigned NW    = 256;
    localparam logic [31:0] START = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] wr_data, rd_data, mem_addr, mem_d_in, mem_d_out;
    logic        wr_valid, wr_ready, rd_valid, done, err, mem_en, mem_wren, mem_busy;
    logic [1:0]  mem_acc_size;

    mem_burst_master #(
        .ADDRESS_SIZE(32), .DATA_SIZE(32), .START_ADDRESS(START),
        .MEM_SIZE(MEMSZ), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wr(req_wr), .req_size(req_size),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
        .mem_en(mem_en), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_acc_size(mem_acc_size), .mem_d_in(mem_d_in), .mem_d_out(mem_d_out),
        .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Memory contents seen by the DUT, and the model's own copy
    logic [31:0] dut_arr [NW];
    logic [31:0] mdl_arr [NW];

    // Per-cycle expectations and stimulus for one burst; cycle 0 is the accept cycle
    bit          e_en [MAXC], e_wren [MAXC], e_wrr [MAXC], e_rdv [MAXC];
    bit          e_done [MAXC], e_err [MAXC], e_rr [MAXC];
    logic [31:0] e_addr [MAXC], e_rdd [MAXC], e_din [MAXC];
    int          e_len;
    bit          i_busy [MAXC], i_wv [MAXC];
    logic [31:0] i_wd [MAXC];
    logic [31:0] wwords [16];

    bit          chk_on = 1'b0;
    bit          idle_chk = 1'b0;
    int          ci = 0;
    logic [1:0]  cur_sz = 2'b00;

    int          obs_en_cnt, obs_wrr, obs_done_cyc, obs_err, obs_rdv_first;
    logic [31:0] obs_rd [$];
    logic [31:0] obs_addr [MAXC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    function automatic bit in_arr(input logic [31:0] a);
        return (a >= START) && ((a - START) < 32'(NW * 4)) && (a[1:0] == 2'b00);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - START) >> 2);
    endfunction

    function automatic logic [31:0] dut_read(input logic [31:0] a);
        return in_arr(a) ? dut_arr[widx(a)] : (a ^ 32'hC3A5_5A3C);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        return in_arr(a) ? mdl_arr[widx(a)] : (a ^ 32'hC3A5_5A3C);
    endfunction

    // Behavioural model: walk the burst cycle by cycle from the protocol rules
    task automatic build(input logic [31:0] a, input bit wr, input logic [1:0] sz);
        int n, left, tmo, c, wi;
        bit rej, ferr, pend, en;
        logic [31:0] ad, pd;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
        for (int k = 0; k < MAXC; k++) begin
            e_en[k] = 0; e_wren[k] = 0; e_wrr[k] = 0; e_rdv[k] = 0;
            e_done[k] = 0; e_err[k] = 0; e_rr[k] = 0;
            e_addr[k] = '0; e_rdd[k] = '0; e_din[k] = '0;
        end
        e_rr[0] = 1;
        rej = (a[1:0] != 2'b00) || (a < START) ||
              ((64'(a) - 64'(START)) + 64'(4 * n) > 64'(MEMSZ));
        ferr = rej;
        c = 2;
        if (!rej) begin
            left = n; ad = a; tmo = 0; pend = 0; pd = '0; wi = 0;
            while (c < int'(MAXC) - 2) begin
                e_rdv[c] = pend; e_rdd[c] = pd; pend = 0;
                en = wr ? i_wv[c] : 1'b1;
                e_en[c] = en; e_wren[c] = wr && en; e_addr[c] = ad;
                if (wr) i_wd[c] = wwords[wi];
                e_din[c] = i_wd[c];
                if (en && i_busy[c]) begin
                    e_wrr[c] = wr;
                    if (wr) begin
                        if (in_arr(ad)) mdl_arr[widx(ad)] = wwords[wi];
                    end else begin
                        pend = 1; pd = mdl_read(ad);
                    end
                    wi++; ad = ad + 32'd4; left--; tmo = 0; c++;
                    if (left == 0) break;
                end else begin
                    if (en) tmo++;
                    c++;
                    if (tmo == int'(TMO)) begin ferr = 1; break; end
                end
            end
            e_rdv[c] = pend; e_rdd[c] = pd;
        end
        e_done[c] = 1; e_err[c] = ferr; e_len = c + 1;
    endtask

    task automatic set_patterns(input int busy_pct, input int wv_pct);
        for (int c = 0; c < MAXC; c++) begin
            i_busy[c] = (c >= 200) ? 1'b1 : ($urandom_range(0, 99) < busy_pct);
            i_wv[c]   = (c >= 200) ? 1'b1 : ($urandom_range(0, 99) < wv_pct);
            i_wd[c]   = $urandom;
        end
        for (int k = 0; k < 16; k++) wwords[k] = $urandom;
    endtask

    task automatic run_burst(input logic [31:0] a, input bit wr, input logic [1:0] sz);
        build(a, wr, sz);
        cur_sz = sz;
        obs_en_cnt = 0; obs_wrr = 0; obs_done_cyc = -1; obs_err = 0; obs_rdv_first = -1;
        obs_rd.delete();
        idle_chk = 0; chk_on = 1;
        for (int c = 0; c < e_len; c++) begin
            ci        = c;
            req_valid = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            req_addr  = (c == 0) ? a : $urandom;
            req_wr    = (c == 0) ? wr : 1'($urandom_range(0, 1));
            req_size  = (c == 0) ? sz : 2'($urandom_range(0, 3));
            wr_valid  = i_wv[c];
            wr_data   = i_wd[c];
            mem_busy  = i_busy[c];
            mem_d_out = dut_read(mem_addr);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        idle_chk = 1; chk_on = 1;
        for (int k = 0; k < n; k++) begin
            req_valid = 1'b0;
            wr_valid  = 1'($urandom_range(0, 1));
            wr_data   = $urandom;
            mem_busy  = 1'($urandom_range(0, 1));
            mem_d_out = $urandom;
            @(posedge clk); #1;
        end
    endtask

    // Single compare process; also acts as the memory's write port
    initial forever begin
        @(negedge clk);
        if (rst_n && mem_en && mem_wren && mem_busy && in_arr(mem_addr))
            dut_arr[widx(mem_addr)] = mem_d_in;
        if (chk_on && idle_chk) begin
            chk("idle_req_ready", 32'(req_ready), 32'd1);
            chk("idle_mem_en", 32'(mem_en), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_rd_valid", 32'(rd_valid), 32'd0);
            chk("idle_wr_ready", 32'(wr_ready), 32'd0);
        end else if (chk_on) begin
            chk("req_ready", 32'(req_ready), 32'(e_rr[ci]));
            chk("mem_en", 32'(mem_en), 32'(e_en[ci]));
            chk("mem_wren", 32'(mem_wren), 32'(e_wren[ci]));
            chk("wr_ready", 32'(wr_ready), 32'(e_wrr[ci]));
            chk("rd_valid", 32'(rd_valid), 32'(e_rdv[ci]));
            chk("done", 32'(done), 32'(e_done[ci]));
            chk("err", 32'(err), 32'(e_err[ci]));
            if (e_en[ci]) begin
                chk("mem_addr", mem_addr, e_addr[ci]);
                chk("mem_acc_size", 32'(mem_acc_size), 32'(cur_sz));
            end
            if (e_en[ci] && e_wren[ci]) chk("mem_d_in", mem_d_in, e_din[ci]);
            if (e_rdv[ci]) chk("rd_data", rd_data, e_rdd[ci]);
            obs_addr[ci] = mem_addr;
            if (mem_en) obs_en_cnt++;
            if (wr_ready) obs_wrr++;
            if (rd_valid) begin
                obs_rd.push_back(rd_data);
                if (obs_rdv_first < 0) obs_rdv_first = ci;
            end
            if (done) begin obs_done_cyc = ci; obs_err = 32'(err); end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, got;
        bit wr;
        logic [1:0] sz;
        int kind;

        for (int k = 0; k < NW; k++) begin
            dut_arr[k] = 32'h5000_0000 + 32'(k * 7);
            mdl_arr[k] = 32'h5000_0000 + 32'(k * 7);
        end
        for (int k = 0; k < 4; k++) begin
            dut_arr[4 + k] = 32'(17 * (k + 1));
            mdl_arr[4 + k] = 32'(17 * (k + 1));
        end

        rst_n = 1'b0; req_valid = 1'b0; req_addr = START; req_wr = 1'b1; req_size = 2'b11;
        wr_data = 32'hA5A5_A5A5; wr_valid = 1'b1; mem_busy = 1'b1; mem_d_out = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_d_in", mem_d_in, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Single-word write
        set_patterns(100, 100);
        wwords[0] = 32'hDEAD_BEEF;
        run_burst(32'h8002_0004, 1'b1, 2'b00);
        chk("t1_beats", 32'(obs_en_cnt), 32'd1);
        chk("t1_addr", obs_addr[2], 32'h8002_0004);
        chk("t1_done_cyc", 32'(obs_done_cyc), 32'd3);
        chk("t1_err", 32'(obs_err), 32'd0);
        chk("t1_mem_word", dut_arr[1], 32'hDEAD_BEEF);
        idle(1);

        // 4-beat read of 11/22/33/44
        set_patterns(100, 100);
        run_burst(32'h8002_0010, 1'b0, 2'b01);
        for (int k = 0; k < 4; k++) begin
            got = (k < obs_rd.size()) ? obs_rd[k] : 32'hFFFF_FFFF;
            chk("t2_rd_data", got, 32'(17 * (k + 1)));
            chk("t2_addr", obs_addr[2 + k], 32'h8002_0010 + 32'(4 * k));
        end
        chk("t2_rd_count", 32'(obs_rd.size()), 32'd4);
        chk("t2_first_rdv", 32'(obs_rdv_first), 32'd3);
        chk("t2_done_cyc", 32'(obs_done_cyc), 32'd6);
        idle(1);

        // 8-beat write with a 2-cycle wr_valid gap after beat 3
        set_patterns(100, 100);
        i_wv[5] = 1'b0; i_wv[6] = 1'b0;
        run_burst(32'h8002_0000, 1'b1, 2'b10);
        chk("t3_wr_ready_cnt", 32'(obs_wrr), 32'd8);
        chk("t3_en_cnt", 32'(obs_en_cnt), 32'd8);
        chk("t3_hold_addr5", obs_addr[5], 32'h8002_000C);
        chk("t3_hold_addr6", obs_addr[6], 32'h8002_000C);
        chk("t3_done_cyc", 32'(obs_done_cyc), 32'd12);
        chk("t3_err", 32'(obs_err), 32'd0);
        idle(1);

        // Rejected requests
        set_patterns(100, 100);
        run_burst(32'h8002_0002, 1'b1, 2'b00);
        chk("rej_misalign_cyc", 32'(obs_done_cyc), 32'd2);
        chk("rej_misalign_err", 32'(obs_err), 32'd1);
        chk("rej_misalign_en", 32'(obs_en_cnt), 32'd0);
        run_burst(32'h7FFF_FFFC, 1'b0, 2'b00);
        chk("rej_below_cyc", 32'(obs_done_cyc), 32'd2);
        chk("rej_below_err", 32'(obs_err), 32'd1);
        chk("rej_below_en", 32'(obs_en_cnt), 32'd0);
        run_burst(START + MEMSZ - 32, 1'b0, 2'b11);
        chk("rej_top_cyc", 32'(obs_done_cyc), 32'd2);
        chk("rej_top_err", 32'(obs_err), 32'd1);
        chk("rej_top_en", 32'(obs_en_cnt), 32'd0);
        run_burst(START + MEMSZ - 64, 1'b0, 2'b11);
        chk("top_fit_cyc", 32'(obs_done_cyc), 32'd18);
        chk("top_fit_err", 32'(obs_err), 32'd0);
        idle(1);

        // Read with the memory never responding
        set_patterns(0, 100);
        run_burst(32'h8002_0040, 1'b0, 2'b01);
        chk("tmo_done_cyc", 32'(obs_done_cyc), 32'd10);
        chk("tmo_err", 32'(obs_err), 32'd1);
        chk("tmo_en_cnt", 32'(obs_en_cnt), 32'd8);
        idle(2);

        // Random bursts
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 7)       a = START + 32'(4 * $urandom_range(0, NW - 16));
            else if (kind == 7) a = START + MEMSZ - 32'(4 * $urandom_range(1, 20));
            else if (kind == 8) begin
                a = START + 32'($urandom_range(0, 1000));
                a[1:0] = 2'($urandom_range(1, 3));
            end else            a = START - 32'(4 * $urandom_range(1, 8));
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            set_patterns(($urandom_range(0, 5) == 0) ? 15 : 80, 75);
            run_burst(a, wr, sz);
            idle($urandom_range(0, 2));
        end
        for (int k = 0; k < NW; k++) chk("final_mem", dut_arr[k], mdl_arr[k]);

        // Reset during beat 2 of a 16-beat read
        chk_on = 1'b0;
        req_valid = 1'b1; req_addr = START + 32'h100; req_wr = 1'b0; req_size = 2'b11;
        mem_busy = 1'b1; wr_valid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        mem_d_out = 32'h1234_5678;
        @(posedge clk); #1;
        chk("rst_mid_active", 32'(mem_en), 32'd1);
        wr_data = 32'hFFFF_FFFF;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mid_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_mid_mem_addr", mem_addr, 32'd0);
        chk("rst_mid_acc_size", 32'(mem_acc_size), 32'd0);
        chk("rst_mid_mem_d_in", mem_d_in, 32'd0);
        chk("rst_mid_rd_data", rd_data, 32'd0);
        chk("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_wr_ready", 32'(wr_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("post_rst_req_ready", 32'(req_ready), 32'd1);
            chk("post_rst_done", 32'(done), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
